// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port integer register file with a per-register
// busy scoreboard and a post-reset clearing sweep. Register 0 is hardwired to zero.
module reg_file_mp #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int NWR    = 2,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NRD*AW-1:0]    rd_addr,
   output logic [NRD*XLEN-1:0]  rd_data,
   output logic [NRD-1:0]       rd_busy,
   input  logic [NWR-1:0]       wr_en,
   input  logic [NWR*AW-1:0]    wr_addr,
   input  logic [NWR*XLEN-1:0]  wr_data,
   input  logic                 alloc_en,
   input  logic [AW-1:0]        alloc_addr,
   output logic                 init_done
);

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   state_t              state_q, state_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic                initDone_q, initDone_d;
   logic [NREGS-1:0]    busy_q, busy_d;
   logic [XLEN-1:0]     regs_q [NREGS];

   logic [AW-1:0]       rdA;
   logic [XLEN-1:0]     rdD;
   logic                rdB;
   logic                fwdHit;

   // Next-state logic: the sweep walks every index once, then the scoreboard
   // tracks allocations (set) and writebacks (clear), allocation taking priority.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      initDone_d = initDone_q;
      busy_d     = busy_q;
      case (state_q)
         INIT: begin
            idx_d = idx_q + AW'(1);
            if (idx_q == AW'(NREGS - 1)) begin
               state_d    = RUN;
               initDone_d = 1'b1;
               idx_d      = '0;
            end
         end
         RUN: begin
            for (int j = 0; j < NWR; j++) begin
               if (wr_en[j]) begin
                  busy_d[wr_addr[j*AW +: AW]] = 1'b0;
               end
            end
            if (alloc_en) begin
               busy_d[alloc_addr] = 1'b1;
            end
            busy_d[0] = 1'b0;
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   // Control state, sweep index, init_done flag and busy bits; reset restarts the sweep.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= INIT;
         idx_q      <= '0;
         initDone_q <= 1'b0;
         busy_q     <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         initDone_q <= initDone_d;
         busy_q     <= busy_d;
      end
   end

   // Storage array: cleared one entry per cycle during the sweep, written by the
   // write ports afterwards; later ports override earlier ones on the same address.
   always_ff @(posedge clk) begin
      if (state_q == INIT) begin
         regs_q[idx_q] <= '0;
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
               regs_q[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
            end
         end
      end
   end

   // Read ports: array value with optional same-cycle forwarding from the
   // highest matching write port; zero during the sweep and for register 0.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      rdA     = '0;
      rdD     = '0;
      rdB     = 1'b0;
      fwdHit  = 1'b0;
      for (int k = 0; k < NRD; k++) begin
         rdA    = rd_addr[k*AW +: AW];
         rdD    = regs_q[rdA];
         rdB    = busy_q[rdA];
         fwdHit = 1'b0;
         if (BYPASS != 0) begin
            for (int j = 0; j < NWR; j++) begin
               if (wr_en[j] && (wr_addr[j*AW +: AW] == rdA)) begin
                  rdD    = wr_data[j*XLEN +: XLEN];
                  fwdHit = 1'b1;
               end
            end
         end
         if (fwdHit && !(alloc_en && (alloc_addr == rdA))) begin
            rdB = 1'b0;
         end
         if ((state_q != RUN) || (rdA == '0)) begin
            rdD = '0;
            rdB = 1'b0;
         end
         rd_data[k*XLEN +: XLEN] = rdD;
         rd_busy[k]              = rdB;
      end
   end

   assign init_done = initDone_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: scoreboard bench for reg_file_mp. The driver predicts each
// cycle's outputs from a behavioural model and queues them; a monitor compares.
module tb_reg_file_mp;

   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int NRD    = 2;
   localparam int NWR    = 2;
   localparam int BYPASS = 1;
   localparam int AW     = $clog2(NREGS);

   logic                 clk;
   logic                 rst;
   logic [NRD*AW-1:0]    rdAddr;
   logic [NRD*XLEN-1:0]  rdData;
   logic [NRD-1:0]       rdBusy;
   logic [NWR-1:0]       wrEn;
   logic [NWR*AW-1:0]    wrAddr;
   logic [NWR*XLEN-1:0]  wrData;
   logic                 allocEn;
   logic [AW-1:0]        allocAddr;
   logic                 initDone;

   typedef struct packed {
      logic [NRD*XLEN-1:0] data;
      logic [NRD-1:0]      busy;
      logic                initDone;
   } exp_t;

   exp_t expQ[$];
   int   checks;
   int   failures;

   logic [XLEN-1:0] mRegs [NREGS];
   bit              mBusy [NREGS];
   bit              mRun;
   int              mCount;

   reg_file_mp #(
      .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(BYPASS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rd_addr(rdAddr),
      .rd_data(rdData),
      .rd_busy(rdBusy),
      .wr_en(wrEn),
      .wr_addr(wrAddr),
      .wr_data(wrData),
      .alloc_en(allocEn),
      .alloc_addr(allocAddr),
      .init_done(initDone)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model reset: back to sweeping with an empty scoreboard.
   task automatic modelReset();
      mRun   = 1'b0;
      mCount = 0;
      for (int i = 0; i < NREGS; i++) mBusy[i] = 1'b0;
   endtask

   // Expected outputs for the inputs currently applied, from the model state.
   function automatic exp_t predict();
      exp_t            e;
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
      bit              b;
      e = '0;
      e.initDone = mRun;
      if (mRun) begin
         for (int k = 0; k < NRD; k++) begin
            a = rdAddr[k*AW +: AW];
            d = '0;
            b = 1'b0;
            if (a != '0) begin
               d = mRegs[a];
               b = mBusy[a];
               for (int j = 0; j < NWR; j++) begin
                  if (wrEn[j] && wrAddr[j*AW +: AW] == a) begin
                     d = wrData[j*XLEN +: XLEN];
                     b = (allocEn && allocAddr == a) ? mBusy[a] : 1'b0;
                  end
               end
            end
            e.data[k*XLEN +: XLEN] = d;
            e.busy[k]              = b;
         end
      end
      return e;
   endfunction

   // Model clock edge: count the sweep, or apply writes then the allocation.
   task automatic modelEdge();
      int a;
      if (rst) return;
      if (!mRun) begin
         mCount++;
         if (mCount == NREGS) begin
            mRun = 1'b1;
            for (int i = 0; i < NREGS; i++) mRegs[i] = '0;
         end
      end else begin
         for (int j = 0; j < NWR; j++) begin
            a = int'(wrAddr[j*AW +: AW]);
            if (wrEn[j] && a != 0) begin
               mRegs[a] = wrData[j*XLEN +: XLEN];
               mBusy[a] = 1'b0;
            end
         end
         if (allocEn && allocAddr != '0) mBusy[allocAddr] = 1'b1;
      end
   endtask

   // Queue the prediction for this cycle, then advance one clock.
   task automatic applyStimulus();
      if (rst) modelReset();
      expQ.push_back(predict());
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   // Compare one set of sampled outputs against a queued prediction.
   task automatic checkOutput(input exp_t e);
      checks++;
      if (rdData !== e.data) begin
         failures++;
         $display("[TB] FAIL rd_data t=%0t addr=%h got=%h exp=%h", $time, rdAddr, rdData, e.data);
      end
      checks++;
      if (rdBusy !== e.busy) begin
         failures++;
         $display("[TB] FAIL rd_busy t=%0t addr=%h got=%b exp=%b", $time, rdAddr, rdBusy, e.busy);
      end
      checks++;
      if (initDone !== e.initDone) begin
         failures++;
         $display("[TB] FAIL init_done t=%0t got=%b exp=%b", $time, initDone, e.initDone);
      end
   endtask

   task automatic clearCtl();
      wrEn      = '0;
      wrAddr    = '0;
      wrData    = '0;
      allocEn   = 1'b0;
      allocAddr = '0;
   endtask

   task automatic setRead(input int k, input int a);
      rdAddr[k*AW +: AW] = AW'(a);
   endtask

   task automatic setWrite(input int j, input int a, input logic [XLEN-1:0] d);
      wrEn[j]                 = 1'b1;
      wrAddr[j*AW +: AW]      = AW'(a);
      wrData[j*XLEN +: XLEN]  = d;
   endtask

   task automatic setAlloc(input int a);
      allocEn   = 1'b1;
      allocAddr = AW'(a);
   endtask

   // Monitor: outputs are always presented, so one prediction is consumed per cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog t=%0t got=timeout exp=finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Stimulus: directed scenarios followed by a randomized phase.
   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      rdAddr   = '0;
      clearCtl();
      modelReset();
      repeat (2) @(posedge clk);
      #1;

      // Sweep with random traffic that must be ignored.
      rst = 1'b0;
      for (int c = 0; c < NREGS; c++) begin
         wrEn    = NWR'($urandom);
         wrAddr  = NWR*AW'($urandom);
         wrData  = {$urandom, $urandom};
         allocEn = 1'($urandom);
         allocAddr = AW'($urandom);
         rdAddr  = NRD*AW'($urandom);
         applyStimulus();
      end
      clearCtl();

      // Every register reads zero after the sweep.
      for (int a = 0; a < NREGS; a += 2) begin
         setRead(0, a);
         setRead(1, a + 1);
         applyStimulus();
      end

      // Write then read, bypassed and registered.
      setWrite(0, 5, 32'hDEADBEEF);
      setRead(0, 5);
      setRead(1, 6);
      applyStimulus();
      clearCtl();
      applyStimulus();

      // Two ports writing the same register.
      setWrite(0, 7, 32'h11);
      setWrite(1, 7, 32'h22);
      setRead(0, 7);
      setRead(1, 7);
      applyStimulus();
      clearCtl();
      applyStimulus();

      // Register 0 ignores writes and allocations.
      setWrite(0, 0, 32'hFFFFFFFF);
      setWrite(1, 0, 32'hFFFFFFFF);
      setAlloc(0);
      setRead(0, 0);
      setRead(1, 0);
      applyStimulus();
      clearCtl();
      applyStimulus();

      // Scoreboard: allocate, observe busy, release by writeback, then alloc+write.
      setAlloc(3);
      setRead(0, 3);
      setRead(1, 5);
      applyStimulus();
      clearCtl();
      applyStimulus();
      setWrite(0, 3, 32'h42);
      applyStimulus();
      clearCtl();
      setWrite(1, 3, 32'h55);
      setAlloc(3);
      applyStimulus();
      clearCtl();
      applyStimulus();

      // Reset mid-run with reg9 written and busy.
      setWrite(0, 9, 32'h99);
      setAlloc(9);
      setRead(0, 9);
      setRead(1, 3);
      applyStimulus();
      clearCtl();
      applyStimulus();
      rst = 1'b1;
      applyStimulus();
      applyStimulus();
      rst = 1'b0;
      for (int c = 0; c < NREGS + 2; c++) begin
         applyStimulus();
      end

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 1500; c++) begin
         rst = ($urandom_range(0, 299) == 0);
         clearCtl();
         for (int j = 0; j < NWR; j++) begin
            if ($urandom_range(0, 1) == 1) begin
               setWrite(j, $urandom_range(0, NREGS - 1), $urandom);
            end
         end
         if ($urandom_range(0, 2) == 0) setAlloc($urandom_range(0, NREGS - 1));
         for (int k = 0; k < NRD; k++) begin
            if ($urandom_range(0, 1) == 1) begin
               setRead(k, int'(wrAddr[$urandom_range(0, NWR - 1)*AW +: AW]));
            end else begin
               setRead(k, $urandom_range(0, NREGS - 1));
            end
         end
         applyStimulus();
      end
      rst = 1'b0;
      clearCtl();
      applyStimulus();

      // Let the monitor drain the queue, bounded.
      for (int w = 0; w < 5 && expQ.size() > 0; w++) @(negedge clk);
      #1;
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain got=%0d exp=0", expQ.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
